// File: rtl/io_handshake_unit.sv
// Responder for IN/OUT instructions: stalls the fetch path, waits for a debounced
// Enter press, then captures switches (IN) or updates the display (OUT).
module io_handshake_unit #(
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 6,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  logic              in_req,
  input  logic              out_req,
  input  logic [DATA_W-1:0] switches,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              reg_write,
  output logic [DATA_W-1:0] display,
  output logic              io_wait,
  output logic              io_done,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    WAIT_PRESS = 3'd2,
    DEBOUNCE   = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              op_in_q;
  logic [DATA_W-1:0] pend_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] display_q;
  logic              reg_write_q;
  logic              io_done_q;
  logic              req;

  assign req = in_req | out_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_in_q     <= 1'b0;
      pend_q      <= '0;
      rd_data_q   <= '0;
      display_q   <= '0;
      reg_write_q <= 1'b0;
      io_done_q   <= 1'b0;
    end else begin
      reg_write_q <= 1'b0;
      io_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            op_in_q <= in_req;
            if (!in_req) pend_q <= wr_data;
            state_q <= ARM;
          end
        end
        // A button already held when the request arrives must be released first.
        ARM: begin
          if (!req) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (!enter) begin
            state_q <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!req) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (enter) begin
            cnt_q   <= CNT_ONE;
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!req) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (!enter) begin
            cnt_q   <= '0;
            state_q <= WAIT_PRESS;
          end else if (cnt_q == CNT_MAX) begin
            if (op_in_q) begin
              rd_data_q   <= switches;
              reg_write_q <= 1'b1;
            end else begin
              display_q <= pend_q;
            end
            io_done_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Stall drops in DONE so the PC loads the next address in that cycle.
  assign io_wait     = req & (state_q != DONE);
  assign rd_data     = rd_data_q;
  assign reg_write   = reg_write_q;
  assign display     = display_q;
  assign io_done     = io_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Directed bench for io_handshake_unit: reset, OUT, IN, bounce rejection,
// back-to-back operations and mid-debounce abort/reset.
module tb_io_handshake_unit;

  localparam int DW = 32;
  localparam int DB = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          enter;
  logic          in_req;
  logic          out_req;
  logic [DW-1:0] switches;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          reg_write;
  logic [DW-1:0] display;
  logic          io_wait;
  logic          io_done;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  io_handshake_unit #(.DATA_W(DW), .DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enter(enter), .in_req(in_req), .out_req(out_req),
    .switches(switches), .wr_data(wr_data), .rd_data(rd_data), .reg_write(reg_write),
    .display(display), .io_wait(io_wait), .io_done(io_done), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enter = 1'b0; in_req = 1'b0; out_req = 1'b0;
    switches = '0; wr_data = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rd_data !== 32'h0 || display !== 32'h0 || io_wait !== 1'b0 ||
          io_done !== 1'b0 || reg_write !== 1'b0 || dbg_state !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: rd=%h disp=%h wait=%b done=%b rw=%b st=%0d, expected 0s", i,
                 rd_data, display, io_wait, io_done, reg_write, dbg_state);
      end
    end
  endtask

  task automatic test_out();
    out_req = 1'b1; wr_data = 32'h0000_00A5; enter = 1'b0;
    #1;
    checks++;
    if (io_wait !== 1'b1) begin
      errors++; $display("FAIL out_wait_first: got %b expected 1", io_wait);
    end
    tick(); tick();
    enter = 1'b1;
    for (int k = 1; k <= DB + 1; k++) begin
      tick();
      checks++;
      if (k <= DB) begin
        if (io_done !== 1'b0 || io_wait !== 1'b1 || display !== 32'h0 || reg_write !== 1'b0) begin
          errors++;
          $display("FAIL out_pending k=%0d: done=%b wait=%b disp=%h rw=%b expected 0/1/0/0", k,
                   io_done, io_wait, display, reg_write);
        end
      end else begin
        if (io_done !== 1'b1 || io_wait !== 1'b0 || display !== 32'hA5 || reg_write !== 1'b0) begin
          errors++;
          $display("FAIL out_commit: done=%b wait=%b disp=%h rw=%b expected 1/0/a5/0",
                   io_done, io_wait, display, reg_write);
        end
      end
    end
    out_req = 1'b0; enter = 1'b0;
    tick();
    checks++;
    if (io_done !== 1'b0 || display !== 32'hA5 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL out_after: done=%b disp=%h st=%0d expected 0/a5/0", io_done, display, dbg_state);
    end
  endtask

  task automatic test_in();
    in_req = 1'b1; switches = 32'h0000_1234; enter = 1'b0;
    tick(); tick();
    enter = 1'b1;
    for (int k = 1; k <= DB; k++) tick();
    checks++;
    if (io_done !== 1'b0 || rd_data !== 32'h0) begin
      errors++; $display("FAIL in_early: done=%b rd=%h expected 0/0", io_done, rd_data);
    end
    switches = 32'h0000_1234;
    tick();
    checks++;
    if (rd_data !== 32'h1234 || reg_write !== 1'b1 || io_done !== 1'b1 || display !== 32'hA5) begin
      errors++;
      $display("FAIL in_commit: rd=%h rw=%b done=%b disp=%h expected 1234/1/1/a5",
               rd_data, reg_write, io_done, display);
    end
    in_req = 1'b0; enter = 1'b0;
    tick();
    checks++;
    if (reg_write !== 1'b0 || io_done !== 1'b0 || rd_data !== 32'h1234) begin
      errors++;
      $display("FAIL in_pulse_width: rw=%b done=%b rd=%h expected 0/0/1234", reg_write, io_done, rd_data);
    end
  endtask

  task automatic test_bounce();
    int early;
    early = 0;
    enter = 1'b1; in_req = 1'b1; switches = 32'h0000_BEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (io_done !== 1'b0 || rd_data !== 32'h1234) early++;
    end
    checks++;
    if (early != 0 || dbg_state !== 3'd1) begin
      errors++; $display("FAIL bounce_held: early=%0d st=%0d expected 0/1", early, dbg_state);
    end
    enter = 1'b0; tick();
    enter = 1'b1; for (int i = 0; i < 3; i++) tick();
    enter = 1'b0; tick();
    checks++;
    if (io_done !== 1'b0 || dbg_state !== 3'd2 || rd_data !== 32'h1234) begin
      errors++;
      $display("FAIL bounce_burst: done=%b st=%0d rd=%h expected 0/2/1234", io_done, dbg_state, rd_data);
    end
    enter = 1'b1;
    for (int k = 1; k <= DB + 1; k++) tick();
    checks++;
    if (io_done !== 1'b1 || rd_data !== 32'hBEEF || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL bounce_commit: done=%b rd=%h rw=%b expected 1/beef/1", io_done, rd_data, reg_write);
    end
    in_req = 1'b0; enter = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int early;
    early = 0;
    in_req = 1'b1; switches = 32'h0000_0055; enter = 1'b0;
    tick(); tick();
    enter = 1'b1;
    for (int k = 1; k <= DB + 1; k++) tick();
    checks++;
    if (io_done !== 1'b1 || rd_data !== 32'h55) begin
      errors++; $display("FAIL b2b_in_commit: done=%b rd=%h expected 1/55", io_done, rd_data);
    end
    in_req = 1'b0; out_req = 1'b1; wr_data = 32'h0000_0077;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (io_done !== 1'b0 || display !== 32'hA5 || io_wait !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL b2b_out_held: bad_cycles=%0d expected 0", early);
    end
    enter = 1'b0; tick();
    enter = 1'b1;
    for (int k = 1; k <= DB + 1; k++) tick();
    checks++;
    if (io_done !== 1'b1 || display !== 32'h77 || reg_write !== 1'b0 || rd_data !== 32'h55) begin
      errors++;
      $display("FAIL b2b_out_commit: done=%b disp=%h rw=%b rd=%h expected 1/77/0/55",
               io_done, display, reg_write, rd_data);
    end
    out_req = 1'b0; enter = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    in_req = 1'b1; switches = 32'h0000_0999; enter = 1'b0;
    tick(); tick();
    enter = 1'b1; for (int i = 0; i < 3; i++) tick();
    in_req = 1'b0;
    tick();
    checks++;
    if (dbg_state !== 3'd0 || io_done !== 1'b0 || rd_data !== 32'h55 || io_wait !== 1'b0) begin
      errors++;
      $display("FAIL abort_req: st=%0d done=%b rd=%h wait=%b expected 0/0/55/0",
               dbg_state, io_done, rd_data, io_wait);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (io_done !== 1'b0 || reg_write !== 1'b0 || rd_data !== 32'h55) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort_quiet: bad_cycles=%0d expected 0", bad);
    end
    enter = 1'b0;
    out_req = 1'b1; wr_data = 32'h0000_003C;
    tick(); tick();
    enter = 1'b1; for (int i = 0; i < 4; i++) tick();
    reset = 1'b1; out_req = 1'b0;
    tick();
    reset = 1'b0; enter = 1'b0;
    checks++;
    if (dbg_state !== 3'd0 || io_done !== 1'b0 || display !== 32'h0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset: st=%0d done=%b disp=%h rd=%h expected 0/0/0/0",
               dbg_state, io_done, display, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_out();
    test_in();
    test_bounce();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
